// File: rtl/gray_pkg.sv
// Shared types and constants for the round-robin Gray/binary conversion block.
package gray_pkg;

    // Sequencer phases: waiting for a request, converting, presenting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    // Conversion direction carried with each request.
    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    // Default geometry of the block.
    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/gray_conv_arbiter_rr_pick.sv
// Combinational round-robin selector: the first asserted request at or after
// ptr (wrapping modulo NREQ) wins. Output is one-hot plus its index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic found;
    int   pos;

    // Scan requests in rotating order starting at ptr; keep the first hit.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary/Gray converter among NREQ requesters.
// Binary->Gray is one registered cycle; Gray->binary resolves one bit per
// cycle from the MSB down, taking WIDTH-1 cycles.
//
// Handshakes: a request transfers on the rising edge where req_valid[i] and
// req_ready[i] are both high; a response transfers on the rising edge where
// rsp_valid and rsp_ready are both high. While rsp_valid is high, rsp_data
// and rsp_id hold their values until that transfer.
module gray_conv_arbiter
    import gray_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_mode,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    input  logic                  rsp_ready,
    output logic                  busy
);

    // Counter wide enough to hold WIDTH-1.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t            state;
    state_t            state_next;
    logic [IDW-1:0]    ptr;
    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    win_idx;
    logic [WIDTH-1:0]  op_in;
    logic [WIDTH-1:0]  op;
    logic [WIDTH-1:0]  res;
    logic              mode;
    logic [IDW-1:0]    id;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     bit_k;
    logic              accept;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (win_idx)
    );

    // Grants are only offered from IDLE and never while reset is asserted,
    // so a request cannot slip in on the same edge that clears the block.
    assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
    assign accept    = (state == IDLE) && rst_n && (|gnt);
    assign op_in     = req_data[win_idx*WIDTH +: WIDTH];
    assign bit_k     = cnt - CW'(1);

    assign rsp_valid = (state == RESP);
    assign rsp_data  = res;
    assign rsp_id    = id;
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one cycle for B2G, WIDTH-1 cycles for G2B.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (mode == MODE_B2G || cnt == CW'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the winning request, rotate the pointer, run the conversion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr  <= '0;
            op   <= '0;
            res  <= '0;
            mode <= MODE_B2G;
            id   <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op   <= op_in;
                        mode <= req_mode[win_idx];
                        id   <= win_idx;
                        ptr  <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
                        cnt  <= CW'(WIDTH - 1);
                        // The binary MSB equals the Gray MSB; lower bits follow serially.
                        res  <= {op_in[WIDTH-1], {(WIDTH-1){1'b0}}};
                    end
                end
                CONV: begin
                    if (mode == MODE_B2G) begin
                        res <= op ^ (op >> 1);
                    end else begin
                        res[bit_k] <= res[bit_k + CW'(1)] ^ op[bit_k];
                        cnt        <= bit_k;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
